// File: rtl/serial_parity_accumulator.sv
// ---------------------------------------------------------------------------
// serial_parity_accumulator
//
// Folds a serial bit stream into one parity bit per frame of FRAME_LEN bits
// and counts the ones in that frame. Input and output use valid/ready
// handshakes. A finished result is held (with backpressure) until the
// consumer takes it.
//
// Build option:
//   PARITY_CHECK_EN  (macro) - when defined, every frame carries one extra
//                    received parity bit after the data bits. The block
//                    compares that bit with its own parity and flags any
//                    mismatch on out_err. When undefined, out_err is
//                    always 0.
//
// Parameters:
//   FRAME_LEN - data bits per frame (2 .. 2**CNT_W-1, or 2**CNT_W-2 when
//               the received parity bit is also counted)
//   CNT_W     - width of the bit counter and of out_ones
//   ODD       - 0: even parity (XOR of the bits), 1: odd parity (inverted)
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   flush      - synchronous discard of a partial frame (ignored in HOLD)
//   in_valid   - in_bit is valid
//   in_ready   - block accepts in_bit this cycle
//   in_bit     - serial data bit
//   out_valid  - result is valid
//   out_ready  - downstream accepts the result
//   out_parity - frame parity
//   out_ones   - number of 1 data bits in the frame
//   out_err    - received parity mismatch (checker build only)
// ---------------------------------------------------------------------------
module serial_parity_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int ODD       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_ones,
    output logic             out_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    localparam logic ODD_BIT = (ODD != 0);

    // Counter value on the beat that ends the frame. In the checker build
    // the final beat is the received parity bit, one position later.
`ifdef PARITY_CHECK_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             acc_reg, acc_next;
    logic [CNT_W-1:0] ones_reg, ones_next;
    logic             par_reg, par_next;
    logic [CNT_W-1:0] ones_out_reg, ones_out_next;
    logic             in_beat;

`ifdef PARITY_CHECK_EN
    logic             err_reg, err_next;
`endif

    // in_ready is a function of state, flush and reset only, never of the
    // output side, so no combinational path runs from out_ready to in_ready.
    assign in_ready   = rst_n && !flush && (state_reg != ST_HOLD);
    assign in_beat    = in_valid && in_ready;
    assign out_valid  = (state_reg == ST_HOLD);
    assign out_parity = par_reg;
    assign out_ones   = ones_out_reg;

`ifdef PARITY_CHECK_EN
    assign out_err = err_reg;
`else
    assign out_err = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        ones_next     = ones_reg;
        par_next      = par_reg;
        ones_out_next = ones_out_reg;
`ifdef PARITY_CHECK_EN
        err_next      = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (flush) begin
                    cnt_next  = '0;
                    acc_next  = 1'b0;
                    ones_next = '0;
                end else if (in_beat) begin
                    acc_next   = in_bit;
                    ones_next  = CNT_W'(in_bit);
                    cnt_next   = CNT_W'(1);
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (flush) begin
                    cnt_next   = '0;
                    acc_next   = 1'b0;
                    ones_next  = '0;
                    state_next = ST_IDLE;
                end else if (in_beat) begin
                    if (cnt_reg == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
                        // Final beat is the received parity bit: it is
                        // compared, not folded or counted.
                        par_next      = acc_reg ^ ODD_BIT;
                        ones_out_next = ones_reg;
                        err_next      = acc_reg ^ ODD_BIT ^ in_bit;
`else
                        par_next      = acc_reg ^ in_bit ^ ODD_BIT;
                        ones_out_next = ones_reg + CNT_W'(in_bit);
`endif
                        state_next    = ST_HOLD;
                    end else begin
                        acc_next  = acc_reg ^ in_bit;
                        ones_next = ones_reg + CNT_W'(in_bit);
                        cnt_next  = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // flush is deliberately ignored here: a finished frame is
                // always delivered.
                if (out_ready) begin
                    cnt_next   = '0;
                    acc_next   = 1'b0;
                    ones_next  = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= 1'b0;
            ones_reg     <= '0;
            par_reg      <= 1'b0;
            ones_out_reg <= '0;
`ifdef PARITY_CHECK_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            ones_reg     <= ones_next;
            par_reg      <= par_next;
            ones_out_reg <= ones_out_next;
`ifdef PARITY_CHECK_EN
            err_reg      <= err_next;
`endif
        end
    end

endmodule
